seg_status_display: RTL

Registered, parametrised seven-segment status driver for the number-guessing game. It converts the binary countdown timer to BCD with an iterative double-dabble engine and applies leading-zero blanking and overflow dashes. It also renders the guess count, hint, guess digits and round/difficulty LEDs. End-of-game messages ("YOU LOSE" / "GOOD JOB") blink at a programmable rate. It sits between the game FSM and the board's segment/LED pins.

---
 rtl/seg_status_if.sv | 46 ++++
 rtl/seg_status_display.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_status_if.sv
// ---------------------------------------------------------------------------
// seg_status_if
// Bundles the signals between the game FSM (master) and the seven-segment /
// LED status driver (slave).
//
// Signalling: there is no valid/ready handshake on this bus. Every master
// output is a level that the slave samples on every rising clk edge. Every
// slave output is a register that reflects the inputs sampled one edge
// earlier. The timer digits are the exception: they follow the BCD converter
// pipeline.
//
// Master -> slave : timer_val, guesses, hint, guess_digits, round,
//                   difficulty, outcome
// Slave -> master : seg_out (active-low, digit 0 = bits [6:0]), round_led,
//                   diff_led, conv_busy, conv_state (converter FSM state)
// ---------------------------------------------------------------------------
interface seg_status_if #(
  parameter int TIMER_W      = 8,
  parameter int TIMER_DIGITS = 2,
  parameter int NUM_GUESS    = 3
);
  localparam int ND = TIMER_DIGITS + 3 + NUM_GUESS;

  logic [TIMER_W-1:0]     timer_val;
  logic [3:0]             guesses;
  logic [1:0]             hint;
  logic [4*NUM_GUESS-1:0] guess_digits;
  logic [1:0]             round;
  logic [1:0]             difficulty;
  logic [1:0]             outcome;
  logic [7*ND-1:0]        seg_out;
  logic [2:0]             round_led;
  logic [2:0]             diff_led;
  logic                   conv_busy;
  logic [1:0]             conv_state;

  modport master (
    output timer_val, guesses, hint, guess_digits, round, difficulty, outcome,
    input  seg_out, round_led, diff_led, conv_busy, conv_state
  );

  modport slave (
    input  timer_val, guesses, hint, guess_digits, round, difficulty, outcome,
    output seg_out, round_led, diff_led, conv_busy, conv_state
  );
endinterface

// File: rtl/seg_status_display.sv
// ---------------------------------------------------------------------------
// seg_status_display
// Seven-segment status driver for the number-guessing game. The binary
// countdown timer goes through an iterative double-dabble converter. The
// converted value is shown with leading-zero blanking, or as dashes when it
// does not fit in TIMER_DIGITS digits. The display also shows the guess
// count, the hint, the guess digits and the round/difficulty LEDs. Lose and
// win outcomes replace the display with a message that can blink.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         seg_status_if slave modport. The inputs are timer_val,
//               guesses, hint, guess_digits, round, difficulty and outcome.
//               The registered outputs are seg_out, round_led, diff_led and
//               conv_busy. conv_state exposes the converter FSM state.
// ---------------------------------------------------------------------------
module seg_status_display #(
  parameter int TIMER_W      = 8,
  parameter int TIMER_DIGITS = 2,
  parameter int NUM_GUESS    = 3,
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  seg_status_if.slave bus
);
  localparam int ND    = TIMER_DIGITS + 3 + NUM_GUESS;
  localparam int NIB   = (TIMER_W + 2) / 3;
  localparam int BCD_W = 4 * NIB;
  localparam int SH_W  = BCD_W + TIMER_W;
  localparam int MAXN  = (NIB > TIMER_DIGITS) ? NIB : TIMER_DIGITS;
  localparam int BC_W  = $clog2(TIMER_W + 1);
  localparam int CNT_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'((BLINK_CYCLES > 0) ? BLINK_CYCLES - 1 : 0);
  localparam logic [BC_W-1:0]  BIT_LAST = BC_W'(TIMER_W - 1);

  if (ND < 8) begin : g_nd_check
    $error("seg_status_display: TIMER_DIGITS+3+NUM_GUESS must be >= 8");
  end

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [6:0] G_BLANK = 7'h7F;
  localparam logic [6:0] G_DASH  = 7'b0111111;
  localparam logic [6:0] G_UNDER = 7'b1110111;
  localparam logic [6:0] G_H     = 7'b0001001;
  localparam logic [6:0] G_L     = 7'b1000111;
  localparam logic [6:0] G_Y     = 7'b0010001;
  localparam logic [6:0] G_O     = 7'b0100011;
  localparam logic [6:0] G_U     = 7'b1100011;
  localparam logic [6:0] G_S     = 7'b0010010;
  localparam logic [6:0] G_E     = 7'b0000100;
  localparam logic [6:0] G_G     = 7'b0010000;
  localparam logic [6:0] G_D     = 7'b0100001;
  localparam logic [6:0] G_J     = 7'b1110001;
  localparam logic [6:0] G_B     = 7'b0000011;

  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = G_BLANK;
    endcase
    return g;
  endfunction

  function automatic logic [6:0] msg_glyph(input logic win, input int idx);
    logic [6:0] g;
    g = G_BLANK;
    if (win) begin
      case (idx)
        0: g = G_G;  1: g = G_O;  2: g = G_O;  3: g = G_D;
        5: g = G_J;  6: g = G_O;  7: g = G_B;
        default: g = G_BLANK;
      endcase
    end else begin
      case (idx)
        0: g = G_Y;  1: g = G_O;  2: g = G_U;
        4: g = G_L;  5: g = G_O;  6: g = G_S;  7: g = G_E;
        default: g = G_BLANK;
      endcase
    end
    return g;
  endfunction

  function automatic logic [2:0] one_hot3(input logic [1:0] v);
    logic [2:0] r;
    case (v)
      2'd1:    r = 3'b001;
      2'd2:    r = 3'b010;
      2'd3:    r = 3'b100;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  // ---------------- double-dabble converter ----------------
  // The shift register holds the BCD accumulator in its top bits and the
  // binary operand in its low bits.
  logic [1:0]         conv_state;
  logic [SH_W-1:0]    sh;
  logic [SH_W-1:0]    sh_adj;
  logic [BC_W-1:0]    bit_cnt;
  logic [TIMER_W-1:0] last_val;
  logic [BCD_W-1:0]   bcd_res;
  logic               bcd_valid;

  always_comb begin
    sh_adj = sh;
    for (int n = 0; n < NIB; n++) begin
      if (sh[TIMER_W + 4*n +: 4] >= 4'd5)
        sh_adj[TIMER_W + 4*n +: 4] = sh[TIMER_W + 4*n +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_state <= ST_IDLE;
      sh         <= '0;
      bit_cnt    <= '0;
      last_val   <= '0;
      bcd_res    <= '0;
      bcd_valid  <= 1'b0;
    end else begin
      case (conv_state)
        ST_IDLE: begin
          // A missing result forces a conversion even if timer_val still equals last_val.
          if (bus.timer_val != last_val || !bcd_valid) begin
            sh         <= {{BCD_W{1'b0}}, bus.timer_val};
            last_val   <= bus.timer_val;
            bit_cnt    <= '0;
            conv_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          sh      <= {sh_adj[SH_W-2:0], 1'b0};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST)
            conv_state <= ST_DONE;
        end
        ST_DONE: begin
          bcd_res    <= sh[SH_W-1 -: BCD_W];
          bcd_valid  <= 1'b1;
          conv_state <= ST_IDLE;
        end
        default: conv_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------- message blink ----------------
  logic             is_msg;
  logic             is_win;
  logic             prev_msg;
  logic             prev_win;
  logic             msg_restart;
  logic [CNT_W-1:0] blink_cnt;
  logic [CNT_W-1:0] blink_cnt_nx;
  logic             phase_on;
  logic             phase_on_nx;

  assign is_msg      = ~bus.outcome[1];
  assign is_win      = bus.outcome[0];
  assign msg_restart = is_msg && (!prev_msg || (prev_win != is_win));

  always_comb begin
    blink_cnt_nx = '0;
    phase_on_nx  = 1'b1;
    if (is_msg && !msg_restart && (BLINK_CYCLES > 0)) begin
      if (blink_cnt == CNT_MAX) begin
        blink_cnt_nx = '0;
        phase_on_nx  = ~phase_on;
      end else begin
        blink_cnt_nx = blink_cnt + 1'b1;
        phase_on_nx  = phase_on;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase_on  <= 1'b1;
      prev_msg  <= 1'b0;
      prev_win  <= 1'b0;
    end else begin
      blink_cnt <= blink_cnt_nx;
      phase_on  <= phase_on_nx;
      prev_msg  <= is_msg;
      prev_win  <= is_win;
    end
  end

  // ---------------- display composition ----------------
  logic [7*ND-1:0]   seg_nx;
  logic [4*MAXN-1:0] bcd_ext;
  logic              overflow;
  logic              lead;
  logic [3:0]        nib;

  always_comb begin
    bcd_ext                = '0;
    bcd_ext[BCD_W-1:0]     = bcd_res;
    overflow               = 1'b0;
    lead                   = 1'b1;
    nib                    = 4'd0;
    seg_nx                 = {ND{G_BLANK}};
    for (int n = TIMER_DIGITS; n < MAXN; n++) begin
      if (bcd_ext[4*n +: 4] != 4'd0)
        overflow = 1'b1;
    end
    if (is_msg) begin
      // phase_on_nx is the phase being registered this cycle, so a restart
      // shows the message on the first output cycle.
      if (phase_on_nx) begin
        for (int i = 0; i < 8; i++)
          seg_nx[7*i +: 7] = msg_glyph(is_win, i);
      end
    end else begin
      // Timer digit j shows BCD nibble TIMER_DIGITS-1-j. lead stays set
      // while every more-significant nibble is zero.
      for (int j = 0; j < TIMER_DIGITS; j++) begin
        nib = bcd_ext[4*(TIMER_DIGITS-1-j) +: 4];
        if (nib != 4'd0)
          lead = 1'b0;
        if (bcd_valid) begin
          if (overflow)
            seg_nx[7*j +: 7] = G_DASH;
          else if (!lead || (j == TIMER_DIGITS-1))
            seg_nx[7*j +: 7] = digit_glyph(nib);
        end
      end
      if (bus.guesses == 4'd0)
        seg_nx[7*TIMER_DIGITS +: 7] = G_BLANK;
      else if (bus.guesses <= 4'd9)
        seg_nx[7*TIMER_DIGITS +: 7] = digit_glyph(bus.guesses);
      else
        seg_nx[7*TIMER_DIGITS +: 7] = G_DASH;
      case (bus.hint)
        2'd0:    seg_nx[7*(TIMER_DIGITS+1) +: 7] = G_L;
        2'd1:    seg_nx[7*(TIMER_DIGITS+1) +: 7] = G_H;
        default: seg_nx[7*(TIMER_DIGITS+1) +: 7] = G_UNDER;
      endcase
      for (int i = 0; i < NUM_GUESS; i++)
        seg_nx[7*(TIMER_DIGITS+3+i) +: 7] = digit_glyph(bus.guess_digits[4*i +: 4]);
    end
  end

  logic [7*ND-1:0] seg_q;
  logic [2:0]      round_q;
  logic [2:0]      diff_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q   <= {ND{G_BLANK}};
      round_q <= 3'b000;
      diff_q  <= 3'b000;
    end else begin
      seg_q   <= seg_nx;
      round_q <= one_hot3(bus.round);
      diff_q  <= one_hot3(bus.difficulty);
    end
  end

  assign bus.seg_out    = seg_q;
  assign bus.round_led  = round_q;
  assign bus.diff_led   = diff_q;
  assign bus.conv_busy  = (conv_state != ST_IDLE);
  assign bus.conv_state = conv_state;
endmodule
